// File: rtl/mem_readout_streamer_pkg.sv
// rtl/mem_readout_streamer_pkg.sv - shared readout state encoding and word/byte width helpers
// Contents: readout_state_e (FSM encoding), word_width() = (digits+1)*radix_bits*burst,
//           num_bytes() = bytes needed to carry one RAM word.
package mem_readout_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } readout_state_e;

    function automatic int word_width(input int digits, input int rbits, input int burst);
        return (digits + 1) * rbits * burst;
    endfunction

    function automatic int num_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_readout_streamer_serializer.sv
// rtl/mem_readout_streamer_serializer.sv - splits one RAM word into bytes, LSB byte first, valid/ready handshake
// Ports: clk, reset (async active-low), clear (sync cancel, wins over load and transfer),
//        load/load_data (capture a word), ready (downstream accept),
//        out_byte/out_valid (current byte), last_xfer (final byte of the word accepted this cycle).
module readout_byte_serializer #(
    parameter int W  = 33,
    parameter int NB = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    output logic         last_xfer
);

    localparam int SW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [SW-1:0] shift;
    logic [CW-1:0] byte_cnt;
    logic          xfer;

    assign xfer      = out_valid && ready && !clear;
    assign last_xfer = xfer && (byte_cnt == CW'(NB - 1));
    assign out_byte  = shift[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            shift     <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            // zero-extension gives the final byte clean upper bits when W is not a multiple of 8
            shift     <= SW'(load_data);
            byte_cnt  <= '0;
            out_valid <= 1'b1;
        end else if (xfer) begin
            shift <= shift >> 8;
            if (last_xfer) begin
                byte_cnt  <= '0;
                out_valid <= 1'b0;
            end else begin
                byte_cnt <= byte_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_readout_streamer.sv
// rtl/mem_readout_streamer.sv - walks the capture RAM from address 0 and streams every word out as bytes
// Ports: clk, reset (async active-low), start (begin readout pulse), abort (sync cancel),
//        ram_addr/ram_q (RAM read port, 1-cycle latency), out_byte/out_valid/out_ready (byte stream),
//        busy (not idle), done (one-cycle pulse after the last byte is accepted).
module mem_readout_streamer
    import mem_readout_streamer_pkg::*;
#(
    parameter int no_of_digits    = 10,
    parameter int radix_bits      = 3,
    parameter int address_width   = 14,
    parameter int max_ram_address = 4096,
    parameter int burst_index     = 1,
    localparam int W  = word_width(no_of_digits, radix_bits, burst_index),
    localparam int NB = num_bytes(W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    output logic [address_width-1:0] ram_addr,
    input  logic [W-1:0]             ram_q,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [address_width-1:0] LAST_ADDR = address_width'(max_ram_address - 1);

    readout_state_e state, state_nx;
    logic           load;
    logic           addr_clr;
    logic           addr_inc;
    logic           last_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr <= '0;
        end else if (addr_clr) begin
            ram_addr <= '0;
        end else if (addr_inc) begin
            ram_addr <= ram_addr + address_width'(1);
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
            addr_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nx = ST_WAIT;
                        addr_clr = 1'b1;
                    end
                end
                // address was presented on entry; RAM data lands at the end of this cycle
                ST_WAIT: state_nx = ST_LOAD;
                ST_LOAD: begin
                    load     = 1'b1;
                    state_nx = ST_SEND;
                end
                ST_SEND: begin
                    if (last_xfer) begin
                        if (ram_addr == LAST_ADDR) begin
                            state_nx = ST_DONE;
                        end else begin
                            addr_inc = 1'b1;
                            state_nx = ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    addr_clr = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    readout_byte_serializer #(
        .W  (W),
        .NB (NB)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort),
        .load      (load),
        .load_data (ram_q),
        .ready     (out_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_mem_readout_streamer.sv
// tb/tb_mem_readout_streamer.sv - self-checking bench for mem_readout_streamer
module tb_mem_readout_streamer;

    localparam int NB     = 5;
    localparam int NWORDS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [13:0] ram_addr;
    logic [32:0] ram_q;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    mem_readout_streamer #(
        .max_ram_address (NWORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] mem [0:NWORDS-1];
    always @(posedge clk) ram_q <= (ram_addr < 14'(NWORDS)) ? mem[ram_addr[1:0]] : 'x;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          done_cnt;
    int          xfer_cnt;
    int          last_xfer_cyc;
    int          cur_mode;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected stream: every word, little-endian bytes, padded with zeros above bit 32
    task automatic load_model();
        exp_q.delete();
        got_q.delete();
        for (int k = 0; k < NWORDS; k++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back(8'((mem[k] >> (8 * b)) & 33'hFF));
        done_cnt      = 0;
        xfer_cnt      = 0;
        last_xfer_cyc = 0;
        prev_stall    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_byte, prev_byte);
            end
            chk("addr_bound", ram_addr < 14'(NWORDS), 1);
            if (out_valid && out_ready && !abort) begin
                // with out_ready stuck high: 1 cycle between bytes, 3 between words (WAIT, LOAD)
                if (cur_mode == 0 && xfer_cnt > 0)
                    chk("byte_gap", cyc - last_xfer_cyc, (xfer_cnt % NB == 0) ? 3 : 1);
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("byte_value", out_byte, exp_q.pop_front());
                got_q.push_back(out_byte);
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", cyc, last_xfer_cyc + 1);
                chk("done_all_sent", exp_q.size(), 0);
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_byte  = out_byte;
        end
    end

    // mode 0: out_ready always 1; mode 1: out_ready toggles
    task automatic run(input int mode, input bit second_start, input int abort_at);
        bit finished = 1'b0;
        bit aborted  = 1'b0;
        load_model();
        cur_mode = mode;
        mon_en   = 1'b1;
        for (int n = 0; n < 400; n++) begin
            start     = (n == 0) || (second_start && n == 5);
            out_ready = (mode == 0) ? 1'b1 : (n % 2 == 0);
            abort     = 1'b0;
            if (abort_at >= 0 && xfer_cnt == abort_at && out_valid) begin
                abort   = 1'b1;
                aborted = 1'b1;
                chk("abort_byte", out_byte, 8'h67);
            end
            tick();
            if (second_start && n == 0) begin
                chk("lat_busy", busy, 1);
                chk("lat_addr", ram_addr, 0);
                chk("lat_valid0", out_valid, 0);
            end
            if (second_start && n == 1) chk("lat_valid1", out_valid, 0);
            if (second_start && n == 2) chk("lat_valid2", out_valid, 1);
            if (aborted) break;
            if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        if (aborted) begin
            chk("abort_busy", busy, 0);
            chk("abort_valid", out_valid, 0);
            chk("abort_done", done, 0);
            repeat (4) tick();
            chk("abort_no_done", done_cnt, 0);
            chk("abort_idle", busy, 0);
        end else begin
            chk("run_finished", finished, 1);
            chk("run_byte_count", got_q.size(), NWORDS * NB);
            chk("run_exp_empty", exp_q.size(), 0);
            repeat (3) tick();
            chk("run_done_once", done_cnt, 1);
            chk("run_idle", busy, 0);
            chk("run_addr_home", ram_addr, 0);
        end
    endtask

    task automatic chk_literals(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                                input logic [7:0] l3, input logic [7:0] l4);
        logic [7:0] lit [5];
        lit = '{l0, l1, l2, l3, l4};
        for (int i = 0; i < 5; i++)
            chk($sformatf("literal_byte%0d", i), (got_q.size() > i) ? got_q[i] : 8'hxx, lit[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NWORDS; k++) mem[k] = 33'h1_2345_6780 + 33'(k);
        tick();
        tick();
        chk("rst_addr", ram_addr, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // full readout, ready held high, latency and an ignored second start
        run(0, 1'b1, -1);
        chk_literals(8'h80, 8'h67, 8'h45, 8'h23, 8'h01);
        chk("literal_word1_byte0", (got_q.size() > 5) ? got_q[5] : 8'hxx, 8'h81);

        // same data under back-pressure
        run(1, 1'b0, -1);

        // abort while word 2 byte 1 is presented, then a clean restart
        run(0, 1'b0, 11);
        run(0, 1'b0, -1);

        // asynchronous reset mid-SEND of word 1
        mon_en    = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (ram_addr == 14'd1 && out_valid) break;
            tick();
        end
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_addr", ram_addr, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_addr", ram_addr, 0);
        chk("async_byte", out_byte, 0);
        chk("async_valid", out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run(0, 1'b0, -1);

        // all-ones word: top byte carries only bit 32
        mem[0] = 33'h1_FFFF_FFFF;
        run(0, 1'b0, -1);
        chk_literals(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_readout_streamer.md
MEM_READOUT_STREAMER -- requirements
Module: mem_readout_streamer

Interface
REQ-001 Parameter no_of_digits, default 10, digits per captured result word.
REQ-002 Parameter radix_bits, default 3, bits per digit.
REQ-003 Parameter address_width, default 14, RAM address width.
REQ-004 Parameter max_ram_address, default 4096, number of RAM words to read out.
REQ-005 Parameter burst_index, default 1, results per RAM word.
REQ-006 Local width W = (no_of_digits+1)*radix_bits*burst_index; NB = ceil(W/8) bytes per word.
REQ-007 clk  input  1  single clock, same as capture RAM clock.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle pulse from capture-complete (transfer_done); begins readout.
REQ-010 abort  input  1  synchronous cancel; returns to IDLE.
REQ-011 ram_addr  output  address_width  read address to the on-chip RAM.
REQ-012 ram_q  input  W  RAM read data, registered, 1-cycle read latency.
REQ-013 out_byte  output  8  current serialized byte.
REQ-014 out_valid  output  1  out_byte valid.
REQ-015 out_ready  input  1  downstream (UART/host link) accepts byte.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the last byte is accepted.

Function
REQ-018 FSM states: IDLE, WAIT, LOAD, SEND, DONE.
REQ-019 IDLE: start=1 -> ram_addr<=0, byte_cnt<=0, go WAIT; otherwise stay.
REQ-020 WAIT: one cycle for RAM latency, -> LOAD.
REQ-021 LOAD: shift register <= ram_q zero-extended to NB*8 bits, -> SEND.
REQ-022 SEND: out_valid=1, out_byte = shift[7:0], LSB byte first.
REQ-023 Transfer occurs only on a cycle with out_valid=1 and out_ready=1; then shift >>= 8, byte_cnt++.
REQ-024 out_byte and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-025 Transfer of byte NB-1: if ram_addr == max_ram_address-1 -> DONE, else ram_addr++, byte_cnt<=0, -> WAIT.
REQ-026 DONE: done=1 for exactly one cycle, ram_addr<=0, -> IDLE.
REQ-027 Latency: first out_valid high 3 clk edges after the edge sampling start (IDLE->WAIT->LOAD->SEND).
REQ-028 Per-word overhead: 2 idle cycles (WAIT, LOAD) between the last byte of one word and the first byte of the next.
REQ-029 Final byte of each word carries the W mod 8 data bits in its LSBs with zero upper bits (when W mod 8 != 0).
REQ-030 start while busy=1 is ignored.
REQ-031 abort=1 in any state -> IDLE next edge, out_valid=0, done not pulsed; abort has priority over start and over a simultaneous transfer.
REQ-032 ram_addr never exceeds max_ram_address-1; no wrap during readout.

Reset
REQ-033 reset=0 asynchronously forces IDLE, ram_addr=0, byte_cnt=0, shift=0, out_byte=0, out_valid=0, busy=0, done=0.
REQ-034 reset asserted mid-readout discards progress; after release, a new start restarts from address 0.

Structure
REQ-035 State encoding constants and the W/NB width formulas live in the shared package used by the capture-path blocks.
REQ-036 The byte serializer (load, shift, byte_cnt, valid/ready) is one sub-module, readout_byte_serializer; the FSM and address counter stay in the top module.

Verification
REQ-037 W=33 (defaults), max_ram_address=4, RAM preloaded word k = 33'h1_2345_6780+k, out_ready=1 -> 20 bytes; word0 = 80,67,45,23,01; done once, one cycle after the 20th transfer.
REQ-038 Same setup, out_ready toggling 1/0 each cycle -> identical byte sequence, out_byte held constant across every stall cycle.
REQ-039 start pulse at cycle 0 -> ram_addr=0 at cycle 1, out_valid=1 at cycle 3; second start at cycle 5 -> no effect on sequence.
REQ-040 abort asserted during word 2 byte 1 -> next cycle IDLE, busy=0, out_valid=0, no done; subsequent start -> full 20-byte sequence from address 0.
REQ-041 reset=0 asserted between clock edges during SEND -> all outputs 0 immediately, before the next edge.
REQ-042 Word value 33'h1_FFFF_FFFF -> bytes FF,FF,FF,FF,01 (upper 7 bits of last byte zero).
